serial_sub4: RTL and testbench

SERIAL_SUB4 -- requirements
Module: serial_sub4

---
 rtl/serial_sub4.sv | 130 +++++++++++++
 tb/tb_serial_sub4.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub4.sv
// Bit-serial 4-bit subtractor: one full-subtractor cell and a borrow register,
// LSB first, with result registers that only change when an operation completes.
module serial_sub4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout,
  output logic       ovf,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [2:0] r_res;
  logic       r_br;
  logic [1:0] r_cnt;

  logic [3:0] r_diff;
  logic       r_bout;
  logic       r_ovf;

  logic       w_accept;
  logic       w_shift;
  logic       w_last;
  logic       w_d;
  logic       w_br_nxt;

  // Full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] f_full_sub(input logic ai, input logic bi, input logic bri);
    logic d;
    logic bro;
    d   = ai ^ bi ^ bri;
    bro = (~ai & bi) | (~(ai ^ bi) & bri);
    return {bro, d};
  endfunction

  assign {w_br_nxt, w_d} = f_full_sub(r_a[0], r_b[0], r_br);

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_shift  = (r_state == S_SHIFT);
  assign w_last   = w_shift && (r_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (r_cnt == 2'd3) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operands shift right so the cell always sees bit 0; results enter at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= 4'd0;
      r_b    <= 4'd0;
      r_res  <= 3'd0;
      r_br   <= 1'b0;
      r_cnt  <= 2'd0;
      r_diff <= 4'd0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_br  <= bin;
        r_res <= 3'd0;
        r_cnt <= 2'd0;
      end else if (w_shift) begin
        r_a   <= {1'b0, r_a[3:1]};
        r_b   <= {1'b0, r_b[3:1]};
        r_br  <= w_br_nxt;
        r_res <= {w_d, r_res[2:1]};
        r_cnt <= r_cnt + 2'd1;
      end
      // On the MSB cycle r_br is the borrow into bit 3, w_br_nxt the borrow out.
      if (w_last) begin
        r_diff <= {w_d, r_res};
        r_bout <= w_br_nxt;
        r_ovf  <= r_br ^ w_br_nxt;
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_sub4.sv
// Randomized and directed bench for serial_sub4 against an arithmetic reference model.
module tb_serial_sub4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic [3:0] diff;
  logic       bout;
  logic       ovf;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  serial_sub4 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  // Returns {ovf, bout, diff[3:0]} from plain integer arithmetic.
  function automatic logic [5:0] ref_sub(input logic [3:0] ra, input logic [3:0] rb, input logic rbin);
    int u;
    int sa;
    int sb;
    int s;
    logic [5:0] r;
    u    = int'(ra) - int'(rb) - int'(rbin);
    sa   = (ra >= 4'd8) ? int'(ra) - 16 : int'(ra);
    sb   = (rb >= 4'd8) ? int'(rb) - 16 : int'(rb);
    s    = sa - sb - int'(rbin);
    r[3:0] = u[3:0];
    r[4]   = (u < 0);
    r[5]   = (s < -8) || (s > 7);
    return r;
  endfunction

  // Presents an operation for one edge, then scrambles the operand inputs.
  // Returns at the falling edge just after the accepting edge.
  task automatic launch(input logic [3:0] la, input logic [3:0] lb, input logic lbin);
    @(negedge clk);
    start = 1'b1;
    a     = la;
    b     = lb;
    bin   = lbin;
    @(negedge clk);
    start = 1'b0;
    a     = 4'($urandom);
    b     = 4'($urandom);
    bin   = 1'($urandom);
  endtask

  // lat = edge count from the accepting edge (inclusive) to done; 0 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({diff, bout, ovf, busy, done} !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs got diff=%b bout=%b ovf=%b busy=%b done=%b want all 0",
               diff, bout, ovf, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [3:0] va   [4];
    logic [3:0] vb   [4];
    logic       vbin [4];
    logic [5:0] vexp [4];
    int lat;
    va[0] = 4'b0110; vb[0] = 4'b0110; vbin[0] = 1'b0; vexp[0] = {1'b0, 1'b0, 4'b0000};
    va[1] = 4'b0010; vb[1] = 4'b0111; vbin[1] = 1'b1; vexp[1] = {1'b0, 1'b1, 4'b1010};
    va[2] = 4'b1010; vb[2] = 4'b0111; vbin[2] = 1'b1; vexp[2] = {1'b1, 1'b0, 4'b0010};
    va[3] = 4'b1000; vb[3] = 4'b0001; vbin[3] = 1'b0; vexp[3] = {1'b1, 1'b0, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      launch(va[i], vb[i], vbin[i]);
      wait_done(lat);
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL directed%0d_latency got %0d want 5", i, lat);
      end
      checks++;
      if ({ovf, bout, diff} !== vexp[i]) begin
        errors++;
        $display("FAIL directed%0d_result got ovf=%b bout=%b diff=%b want ovf=%b bout=%b diff=%b",
                 i, ovf, bout, diff, vexp[i][5], vexp[i][4], vexp[i][3:0]);
      end
    end
  endtask

  task automatic test_hold();
    logic [5:0] prev;
    logic [5:0] exp;
    prev = {ovf, bout, diff};
    exp  = ref_sub(4'b0101, 4'b0011, 1'b0);
    launch(4'b0101, 4'b0011, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if ({busy, done, ovf, bout, diff} !== {2'b10, prev}) begin
        errors++;
        $display("FAIL hold_shift%0d got busy=%b done=%b ovf=%b bout=%b diff=%b want busy=1 done=0 ovf=%b bout=%b diff=%b",
                 k, busy, done, ovf, bout, diff, prev[5], prev[4], prev[3:0]);
      end
    end
    @(negedge clk);
    checks++;
    if ({done, ovf, bout, diff} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL hold_done got done=%b ovf=%b bout=%b diff=%b want done=1 ovf=%b bout=%b diff=%b",
               done, ovf, bout, diff, exp[5], exp[4], exp[3:0]);
    end
    @(negedge clk);
    checks++;
    if ({busy, done, ovf, bout, diff} !== {2'b00, exp}) begin
      errors++;
      $display("FAIL hold_after got busy=%b done=%b diff=%b want busy=0 done=0 diff=%b",
               busy, done, diff, exp[3:0]);
    end
  endtask

  task automatic test_ignore_start();
    int   ndone;
    int   done_k;
    logic [3:0] got;
    logic busy_after;
    ndone      = 0;
    done_k     = -1;
    got        = 4'bx;
    busy_after = 1'bx;
    launch(4'b0110, 4'b0010, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a     = 4'b1111;
    b     = 4'b0000;
    bin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done_k >= 0 && k == done_k + 1) busy_after = busy;
      if (done === 1'b1) begin
        ndone++;
        if (done_k < 0) begin
          done_k = k;
          got    = diff;
        end
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore_start_pulses got %0d want 1", ndone);
    end
    checks++;
    if (got !== 4'b0100) begin
      errors++;
      $display("FAIL ignore_start_diff got %b want 0100", got);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_busy_after got %b want 0", busy_after);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    int lat;
    launch(4'($urandom), 4'($urandom), 1'($urandom));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({diff, bout, ovf, busy, done} !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got diff=%b bout=%b ovf=%b busy=%b done=%b want all 0",
               diff, bout, ovf, busy, done);
    end
    rst   = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done got %0d pulses want 0", ndone);
    end
    launch(4'b0011, 4'b0001, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL reset_restart_latency got %0d want 5", lat);
    end
    checks++;
    if (diff !== 4'b0010) begin
      errors++;
      $display("FAIL reset_restart_diff got %b want 0010", diff);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rbin;
    logic [5:0] exp;
    int lat;
    for (int i = 0; i < 300; i++) begin
      ra   = 4'($urandom);
      rb   = 4'($urandom);
      rbin = 1'($urandom);
      exp  = ref_sub(ra, rb, rbin);
      launch(ra, rb, rbin);
      wait_done(lat);
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL b2b%0d_latency got %0d want 5", i, lat);
      end
      checks++;
      if (diff !== exp[3:0]) begin
        errors++;
        $display("FAIL b2b%0d_diff a=%b b=%b bin=%b got %b want %b", i, ra, rb, rbin, diff, exp[3:0]);
      end
      checks++;
      if (bout !== exp[4]) begin
        errors++;
        $display("FAIL b2b%0d_bout a=%b b=%b bin=%b got %b want %b", i, ra, rb, rbin, bout, exp[4]);
      end
      checks++;
      if (ovf !== exp[5]) begin
        errors++;
        $display("FAIL b2b%0d_ovf a=%b b=%b bin=%b got %b want %b", i, ra, rb, rbin, ovf, exp[5]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
